// File: rtl/demux_stream.sv
// demux_stream: routes one input stream to channel A or B, each buffered by a
// 2-entry FIFO with a registered output (1-cycle latency, no bypass).

// Per-channel 2-entry FIFO with an 8-bit accepted-beat counter.
module demux_stream_fifo #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full,
    output logic [7:0]       cnt
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic             pop;

    assign valid = (occ != 2'd0);
    assign full  = (occ == 2'd2);
    assign data  = mem[rd_ptr];
    // Empty FIFO never pops because valid is low.
    assign pop   = valid & ready;

    // Storage, pointers, occupancy and counter; reset clears storage so data reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            cnt    <= 8'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
                cnt         <= cnt + 8'd1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// Top: steers accepted beats into the FIFO picked by in_sel.
module demux_stream #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b
);
    logic full_a, full_b;
    logic push_a, push_b;

    // Ready looks only at the selected FIFO's occupancy, so a full FIFO is
    // refused even when it pops in the same cycle, and never blocks the other.
    assign in_ready = in_sel ? ~full_b : ~full_a;
    assign push_a   = in_valid & in_ready & ~in_sel;
    assign push_b   = in_valid & in_ready &  in_sel;

    demux_stream_fifo #(.WIDTH(WIDTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .wdata (in_data),
        .ready (a_ready),
        .data  (a_data),
        .valid (a_valid),
        .full  (full_a),
        .cnt   (cnt_a)
    );

    demux_stream_fifo #(.WIDTH(WIDTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .wdata (in_data),
        .ready (b_ready),
        .data  (b_data),
        .valid (b_valid),
        .full  (full_b),
        .cnt   (cnt_b)
    );
endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed scenarios plus random traffic, checked
// against a queue-based reference model.
module tb_demux_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [7:0] cnt_a, cnt_b;

    int tests = 0;
    int fails = 0;

    // Reference model: per-channel FIFO contents and accept counters.
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [7:0] ca = 8'd0;
    logic [7:0] cb = 8'd0;

    demux_stream #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model after an edge.
    task automatic check_outputs(input string tag);
        chk({tag, ".a_valid"}, a_valid, qa.size() != 0);
        chk({tag, ".b_valid"}, b_valid, qb.size() != 0);
        if (qa.size() != 0) chk({tag, ".a_data"}, a_data, qa[0]);
        if (qb.size() != 0) chk({tag, ".b_data"}, b_data, qb[0]);
        chk({tag, ".cnt_a"}, cnt_a, ca);
        chk({tag, ".cnt_b"}, cnt_b, cb);
    endtask

    // One clock cycle: drive, check ready, advance model across the edge, check outputs.
    task automatic cycle(input string tag, input logic v, input logic s,
                         input logic [3:0] d, input logic ar, input logic br);
        int  sz;
        logic acc, pa, pb;
        in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
        #1;
        sz = s ? qb.size() : qa.size();
        chk({tag, ".in_ready"}, in_ready, sz < 2);
        acc = v && (sz < 2);
        pa  = (qa.size() != 0) && ar;
        pb  = (qb.size() != 0) && br;
        @(posedge clk);
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (acc) begin
            if (s) begin qb.push_back(d); cb++; end
            else   begin qa.push_back(d); ca++; end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".a_valid"}, a_valid, 1'b0);
        chk({tag, ".b_valid"}, b_valid, 1'b0);
        chk({tag, ".a_data"},  a_data,  4'h0);
        chk({tag, ".b_data"},  b_data,  4'h0);
        chk({tag, ".cnt_a"},   cnt_a,   8'h0);
        chk({tag, ".cnt_b"},   cnt_b,   8'h0);
        in_sel = 1'b0; #0.1;
        chk({tag, ".rdy0"}, in_ready, 1'b1);
        in_sel = 1'b1; #0.1;
        chk({tag, ".rdy1"}, in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        #2;
        check_reset_state("rst");
        #1 rst = 1'b0;  // released before the first rising edge

        // Basic routing.
        cycle("route1", 1'b1, 1'b0, 4'h1, 1'b1, 1'b1);
        chk("route1.a1", a_data, 4'h1);
        cycle("route2", 1'b1, 1'b1, 4'h2, 1'b1, 1'b1);
        chk("route2.b2", b_data, 4'h2);
        chk("route2.ca", cnt_a, 8'd1);
        chk("route2.cb", cnt_b, 8'd1);
        cycle("drain0", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        // Fill and backpressure on A; third push held, then full-with-pop.
        cycle("fill3", 1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
        cycle("fill4", 1'b1, 1'b0, 4'h4, 1'b0, 1'b1);
        cycle("fill5", 1'b1, 1'b0, 4'h5, 1'b0, 1'b1);
        chk("fill5.refused", in_ready, 1'b0);
        chk("fill5.head", a_data, 4'h3);
        cycle("fullpop", 1'b1, 1'b0, 4'h5, 1'b1, 1'b1);   // refused, 3 pops
        chk("fullpop.head", a_data, 4'h4);
        cycle("accept5", 1'b1, 1'b0, 4'h5, 1'b1, 1'b1);   // accepted, 4 pops
        chk("accept5.head", a_data, 4'h5);
        cycle("drain1", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        // Channel independence: A full, B still accepts.
        cycle("indA6", 1'b1, 1'b0, 4'h6, 1'b0, 1'b1);
        cycle("indA7", 1'b1, 1'b0, 4'h7, 1'b0, 1'b1);
        cycle("indB",  1'b1, 1'b1, 4'hA, 1'b0, 1'b1);
        chk("indB.b", b_data, 4'hA);
        chk("indB.a", a_data, 4'h6);
        cycle("drain2", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        cycle("drain3", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        // Counter wrap: 256 beats to B.
        begin
            logic [7:0] cb0;
            logic [7:0] ca0;
            cb0 = cb; ca0 = ca;
            for (int i = 0; i < 256; i++)
                cycle("wrap", 1'b1, 1'b1, 4'(i), 1'b1, 1'b1);
            chk("wrap.cnt_b", cnt_b, cb0);
            chk("wrap.cnt_a", cnt_a, ca0);
        end
        cycle("drain4", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        // Reset mid-stream with two beats in each FIFO.
        cycle("pre_a1", 1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
        cycle("pre_a2", 1'b1, 1'b0, 4'hD, 1'b0, 1'b0);
        cycle("pre_b1", 1'b1, 1'b1, 4'hE, 1'b0, 1'b0);
        cycle("pre_b2", 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #0.5;
        check_reset_state("midrst");
        #1 rst = 1'b0;
        qa.delete(); qb.delete(); ca = 8'd0; cb = 8'd0;
        cycle("post1", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        cycle("post2", 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width of the input and both output channels.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-004 Port in_data, input, WIDTH bits, SHALL carry the beat to route.
REQ-005 Port in_sel, input, 1 bit, SHALL select the destination: 0 = channel A, 1 = channel B.
REQ-006 Port in_valid, input, 1 bit, SHALL indicate that in_data/in_sel hold a beat.
REQ-007 Port in_ready, output, 1 bit, SHALL indicate that the selected channel can accept the beat.
REQ-008 Ports a_data (output, WIDTH), a_valid (output, 1) and a_ready (input, 1) SHALL form the channel A output handshake.
REQ-009 Ports b_data (output, WIDTH), b_valid (output, 1) and b_ready (input, 1) SHALL form the channel B output handshake.
REQ-010 Ports cnt_a and cnt_b, output, 8 bits each, SHALL count the beats accepted into A and B respectively.

Function
REQ-011 Each channel SHALL contain a 2-entry FIFO with a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy count (0..2).
REQ-012 in_ready SHALL be combinational: (in_sel ? occB : occA) < 2; it SHALL NOT depend on in_valid or on same-cycle pops.
REQ-013 A beat SHALL be accepted when in_valid && in_ready, and written to the FIFO selected by in_sel; the other FIFO SHALL be untouched.
REQ-014 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL be visible on x_data with x_valid=1 after edge N; there is no combinational bypass.
REQ-015 x_valid SHALL equal (occX != 0), and x_data SHALL equal mem[rd_ptr] of that FIFO.
REQ-016 A pop SHALL occur when x_valid && x_ready, advancing rd_ptr and decrementing occX.
REQ-017 A simultaneous push and pop on the same channel SHALL leave occX unchanged and advance both pointers.
REQ-018 When a FIFO is full (occ=2), a push SHALL be refused even if a pop occurs in the same cycle.
REQ-019 Popping an empty FIFO SHALL be impossible, since x_valid=0; x_ready while empty SHALL be ignored.
REQ-020 Beats SHALL leave each channel in acceptance order; no reordering within a channel SHALL occur; channels are independent.
REQ-021 A full channel SHALL NOT block the other: if A is full and in_sel=1 with B not full, the beat SHALL be accepted to B.
REQ-022 cnt_a/cnt_b SHALL increment by 1 on each beat accepted into A/B and SHALL wrap 255 -> 0.
REQ-023 Changes of in_data/in_sel while in_valid=1 && in_ready=0 SHALL be permitted; only the accept cycle's values SHALL be used.

Reset
REQ-024 Asserting rst SHALL immediately, without waiting for a clock edge, clear both FIFOs' pointers, occupancy and storage to 0, and clear cnt_a and cnt_b.
REQ-025 During reset: a_valid=0, b_valid=0, a_data=0, b_data=0, cnt_a=0, cnt_b=0; in_ready SHALL be 1 for either in_sel value.
REQ-026 Reset asserted mid-operation SHALL discard all buffered beats; no beat SHALL be emitted after rst deasserts unless newly accepted.
REQ-027 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-028 The bench SHALL check basic routing: push 4'h1 with sel=0, then 4'h2 with sel=1, both readies=1 -> a_data=1 one cycle after the first accept, b_data=2 one cycle after the second; cnt_a=1, cnt_b=1.
REQ-029 The bench SHALL check fill and backpressure: a_ready=0, push 4'h3, 4'h4, 4'h5 to A -> first two accepted, in_ready=0 on the third; after setting a_ready=1, the output order SHALL be 3, 4, then 5.
REQ-030 The bench SHALL check channel independence: with A full and a_ready=0, push 4'hA with sel=1 -> accepted immediately, b_data=A next cycle, A contents unchanged.
REQ-031 The bench SHALL check full with same-cycle pop: A full, a_ready=1, in_valid=1, sel=0 -> in_ready=0, occA drops to 1, and the push is accepted the following cycle.
REQ-032 The bench SHALL check counter wrap: 256 beats to B -> cnt_b returns to 0 while cnt_a stays 0.
REQ-033 The bench SHALL check reset mid-stream: with 2 beats buffered in each FIFO, pulse rst between edges -> all outputs are 0 at once, and no stale data appears after release.
